// File: rtl/det_pkg.sv
// Shared definitions for the 5x5 determinant sequencer.
//   state_e     : sequencer FSM encoding (IDLE, LOAD, CALC, DONE)
//   MAT_ELEMS   : number of matrix elements (5x5)
//   DEF_DATA_W  : default element/result width
package det_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int MAT_ELEMS  = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/mod_det_5x5.sv
// Combinational 5x5 determinant, modulo 2^DATA_W.
//   a..y : matrix elements, row-major
//   det  : determinant truncated to DATA_W bits
// All arithmetic wraps at DATA_W bits, so signed and unsigned views agree.
module mod_det_5x5 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a, b, c, d, e,
    input  logic [DATA_W-1:0] f, g, h, i, j,
    input  logic [DATA_W-1:0] k, l, m, n, o,
    input  logic [DATA_W-1:0] p, q, r, s, t,
    input  logic [DATA_W-1:0] u, v, w, x, y,
    output logic [DATA_W-1:0] det
);
    typedef logic [DATA_W-1:0] e_t;

    function automatic e_t det3(input e_t z [9]);
        return z[0] * (z[4] * z[8] - z[5] * z[7])
             - z[1] * (z[3] * z[8] - z[5] * z[6])
             + z[2] * (z[3] * z[7] - z[4] * z[6]);
    endfunction

    // Laplace expansion along row 0.
    function automatic e_t det4(input e_t z [16]);
        e_t acc;
        e_t sub [9];
        int idx;
        acc = '0;
        for (int cc = 0; cc < 4; cc++) begin
            idx = 0;
            for (int rr = 1; rr < 4; rr++)
                for (int jj = 0; jj < 4; jj++)
                    if (jj != cc) begin
                        sub[idx] = z[rr*4+jj];
                        idx++;
                    end
            if (cc % 2 == 1) acc = acc - z[cc] * det3(sub);
            else             acc = acc + z[cc] * det3(sub);
        end
        return acc;
    endfunction

    function automatic e_t det5(input e_t z [25]);
        e_t acc;
        e_t sub [16];
        int idx;
        acc = '0;
        for (int cc = 0; cc < 5; cc++) begin
            idx = 0;
            for (int rr = 1; rr < 5; rr++)
                for (int jj = 0; jj < 5; jj++)
                    if (jj != cc) begin
                        sub[idx] = z[rr*5+jj];
                        idx++;
                    end
            if (cc % 2 == 1) acc = acc - z[cc] * det4(sub);
            else             acc = acc + z[cc] * det4(sub);
        end
        return acc;
    endfunction

    e_t mat [25];

    always_comb begin
        mat = '{a, b, c, d, e, f, g, h, i, j, k, l, m,
                n, o, p, q, r, s, t, u, v, w, x, y};
        det = det5(mat);
    end
endmodule

// File: rtl/det5_load_sequencer.sv
// Serial loader / result sequencer around mod_det_5x5.
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous abort back to IDLE
//   in_data/valid/ready : element stream, row-major a..y
//   res_data/valid/ready: determinant result stream
//   busy                : state != IDLE
//   elem_cnt            : elements accepted so far (0..25)
module det5_load_sequencer
    import det_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CALC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic [4:0]        elem_cnt
);
    typedef logic [DATA_W-1:0] elem_t;

    state_e      state_q, state_d;
    logic [4:0]  elem_cnt_q, elem_cnt_d;
    logic [3:0]  wait_q, wait_d;
    elem_t       res_data_q, res_data_d;
    logic        res_valid_q, res_valid_d;
    logic        in_ready_q, in_ready_d;
    elem_t       regs_q [MAT_ELEMS];
    elem_t       regs_d [MAT_ELEMS];
    elem_t       det;
    logic        accept;

    // in_ready is decoded one cycle early from the next state, so it
    // never depends on in_valid; clear masks it so the element is dropped.
    assign in_ready  = in_ready_q & ~clear;
    assign accept    = in_valid & in_ready;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != IDLE);
    assign elem_cnt  = elem_cnt_q;

    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        wait_d      = wait_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        regs_d      = regs_q;

        for (int s = 0; s < MAT_ELEMS; s++)
            if (accept && elem_cnt_q == 5'(s)) regs_d[s] = in_data;

        if (clear) begin
            state_d     = IDLE;
            elem_cnt_d  = '0;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    elem_cnt_d = 5'd1;
                    state_d    = LOAD;
                end
                LOAD: if (accept) begin
                    elem_cnt_d = elem_cnt_q + 5'd1;
                    if (elem_cnt_q == 5'(MAT_ELEMS - 1)) begin
                        state_d = CALC;
                        wait_d  = 4'(CALC_CYCLES - 1);
                    end
                end
                CALC: begin
                    if (wait_q == '0) begin
                        res_data_d  = det;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        wait_d = wait_q - 4'd1;
                    end
                end
                DONE: if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    elem_cnt_d  = '0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_cnt_q  <= '0;
            wait_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int s = 0; s < MAT_ELEMS; s++) regs_q[s] <= '0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            wait_q      <= wait_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
            regs_q      <= regs_d;
        end
    end

    mod_det_5x5 #(.DATA_W(DATA_W)) u_det (
        .a(regs_q[0]),  .b(regs_q[1]),  .c(regs_q[2]),  .d(regs_q[3]),  .e(regs_q[4]),
        .f(regs_q[5]),  .g(regs_q[6]),  .h(regs_q[7]),  .i(regs_q[8]),  .j(regs_q[9]),
        .k(regs_q[10]), .l(regs_q[11]), .m(regs_q[12]), .n(regs_q[13]), .o(regs_q[14]),
        .p(regs_q[15]), .q(regs_q[16]), .r(regs_q[17]), .s(regs_q[18]), .t(regs_q[19]),
        .u(regs_q[20]), .v(regs_q[21]), .w(regs_q[22]), .x(regs_q[23]), .y(regs_q[24]),
        .det(det)
    );
endmodule
